// File: rtl/integral_image_builder_if.sv
// Pixel-stream input and integral-image buffer write port of integral_image_builder.
// The slave side is the builder; the master side is the pixel source / buffer owner.
interface integral_image_builder_if #(
  parameter int PIX_W  = 4,
  parameter int DATA_W = 21,
  parameter int ADDR_W = 15
) ();
  logic              sof;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              hold_frame;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              frame_done;
  logic              frame_dropped;
  logic              busy;

  modport master (
    output sof, pix_valid, pix_data, hold_frame,
    input  wr_en, wr_addr, wr_data, frame_done, frame_dropped, busy
  );

  modport slave (
    input  sof, pix_valid, pix_data, hold_frame,
    output wr_en, wr_addr, wr_data, frame_done, frame_dropped, busy
  );
endinterface

// File: rtl/integral_image_builder.sv
// Streaming integral-image generator: one registered buffer write per accepted pixel,
// using a running row sum plus a one-row line buffer of the previous row's integrals.
module integral_image_builder #(
  parameter int II_WIDTH  = 160,
  parameter int II_HEIGHT = 120,
  parameter int PIX_W     = 4,
  parameter int DATA_W    = 21,
  parameter int ADDR_W    = 15
) (
  input  logic clk,
  input  logic rst,
  integral_image_builder_if.slave bus
);

  localparam int X_W = $clog2(II_WIDTH);
  localparam int Y_W = $clog2(II_HEIGHT);
  localparam logic [X_W-1:0] X_LAST = X_W'(II_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(II_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_ACC  = 3'b010,
    S_DONE = 3'b100
  } state_t;

  state_t r_state;
  state_t w_next;
  state_t w_case_next;

  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rowsum;
  logic [DATA_W-1:0] r_line [II_WIDTH];

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_frame_done;
  logic              r_frame_dropped;
  logic              r_busy;

  logic              w_sof_hit;
  logic              w_start;
  logic              w_accept;
  logic              w_drop;
  logic              w_last;
  logic [X_W-1:0]    w_x_eff;
  logic [Y_W-1:0]    w_y_eff;
  logic [ADDR_W-1:0] w_addr_eff;
  logic [DATA_W-1:0] w_rowsum_nx;
  logic [DATA_W-1:0] w_line_rd;
  logic [DATA_W-1:0] w_ii;

  // Next-state, pixel acceptance and integral arithmetic for the current pixel.
  always_comb begin
    w_sof_hit   = bus.pix_valid & bus.sof;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_case_next = r_state;
    case (r_state)
      S_IDLE: begin
        w_start  = w_sof_hit & ~bus.hold_frame;
        w_drop   = w_sof_hit & bus.hold_frame;
        w_accept = w_sof_hit & ~bus.hold_frame;
      end
      S_ACC: begin
        // A fresh sof mid-frame restarts at (0,0); hold_frame only gates new frames.
        w_start  = w_sof_hit;
        w_accept = bus.pix_valid;
      end
      S_DONE: begin
        w_case_next = S_IDLE;
      end
      default: begin
        w_case_next = S_IDLE;
      end
    endcase

    w_x_eff     = w_start ? '0 : r_x;
    w_y_eff     = w_start ? '0 : r_y;
    w_addr_eff  = w_start ? '0 : r_addr;
    w_rowsum_nx = ((w_x_eff == '0) ? '0 : r_rowsum) + DATA_W'(bus.pix_data);
    w_line_rd   = (w_y_eff == '0) ? '0 : r_line[w_x_eff];
    w_ii        = w_rowsum_nx + w_line_rd;
    w_last      = (w_x_eff == X_LAST) && (w_y_eff == Y_LAST);
    w_next      = w_accept ? (w_last ? S_DONE : S_ACC) : w_case_next;
  end

  // State, raster counters, row sum and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_x             <= '0;
      r_y             <= '0;
      r_addr          <= '0;
      r_rowsum        <= '0;
      r_wr_en         <= 1'b0;
      r_wr_addr       <= '0;
      r_wr_data       <= '0;
      r_frame_done    <= 1'b0;
      r_frame_dropped <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_wr_en         <= w_accept;
      r_frame_done    <= (r_state == S_DONE);
      r_frame_dropped <= w_drop;
      // Busy spans the whole frame plus the cycle of the final write.
      r_busy          <= (w_next != S_IDLE);
      if (w_accept) begin
        r_rowsum  <= w_rowsum_nx;
        r_addr    <= w_addr_eff + ADDR_W'(1);
        r_wr_addr <= w_addr_eff;
        r_wr_data <= w_ii;
        if (w_x_eff == X_LAST) begin
          r_x <= '0;
          r_y <= (w_y_eff == Y_LAST) ? '0 : (w_y_eff + Y_W'(1));
        end else begin
          r_x <= w_x_eff + X_W'(1);
          r_y <= w_y_eff;
        end
      end else begin
        r_rowsum  <= r_rowsum;
        r_addr    <= r_addr;
        r_wr_addr <= r_wr_addr;
        r_wr_data <= r_wr_data;
        r_x       <= r_x;
        r_y       <= r_y;
      end
    end
  end

  // Line buffer: integral of the previous row, overwritten column by column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < II_WIDTH; i++) begin
        r_line[i] <= '0;
      end
    end else if (w_accept) begin
      r_line[w_x_eff] <= w_ii;
    end else begin
      r_line[w_x_eff] <= r_line[w_x_eff];
    end
  end

  assign bus.wr_en         = r_wr_en;
  assign bus.wr_addr       = r_wr_addr;
  assign bus.wr_data       = r_wr_data;
  assign bus.frame_done    = r_frame_done;
  assign bus.frame_dropped = r_frame_dropped;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_integral_image_builder.sv
// Directed bench for integral_image_builder: constant, random-gapped, aborted,
// held and reset frames, checked with immediate assertions.
module tb_integral_image_builder;
  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst = 1'b0;

  integral_image_builder_if #(.PIX_W(4), .DATA_W(21), .ADDR_W(15)) bus ();

  integral_image_builder #(
    .II_WIDTH(W), .II_HEIGHT(H), .PIX_W(4), .DATA_W(21), .ADDR_W(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fails   = 0;

  logic [20:0] cap [N];
  int     wr_cnt = 0, done_cnt = 0, drop_cnt = 0, msb_err = 0, gap_err = 0;
  longint cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  logic   gap_chk = 1'b0;
  logic   prev_v = 1'b0;

  int rp [N];
  int ex [N];
  int b, d, dr, bad, first_bad;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: captures buffer contents and pulse events away from the edge.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (int'(bus.wr_addr) < N) cap[bus.wr_addr] = bus.wr_data;
      wr_cnt++;
      last_wr_cyc = cyc;
      if (bus.wr_data[20] !== 1'b0) msb_err++;
    end
    if (bus.frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.frame_dropped === 1'b1) drop_cnt++;
    if (gap_chk && (bus.wr_en !== prev_v)) gap_err++;
    prev_v = bus.pix_valid;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic s, input logic [3:0] p);
    bus.sof       = s;
    bus.pix_valid = 1'b1;
    bus.pix_data  = p;
    @(posedge clk);
    #1;
    bus.sof       = 1'b0;
    bus.pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_const(input logic [3:0] p, input int n, input logic first_sof);
    for (int i = 0; i < n; i++) pix(first_sof && (i == 0), p);
  endtask

  initial begin
    bus.sof = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = 4'd0; bus.hold_frame = 1'b0;
    #12;
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_wr_addr", bus.wr_addr, 15'd0);
    chk("rst_wr_data", bus.wr_data, 21'd0);
    chk("rst_frame_done", bus.frame_done, 1'b0);
    chk("rst_frame_dropped", bus.frame_dropped, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b1;
    idle(2);

    // Constant pix=1 frame without gaps
    b = wr_cnt;
    pix(1'b1, 4'd1);
    chk("c1_first_wr_en", bus.wr_en, 1'b1);
    chk("c1_first_addr", bus.wr_addr, 15'd0);
    chk("c1_first_data", bus.wr_data, 21'd1);
    chk("c1_busy", bus.busy, 1'b1);
    send_const(4'd1, N - 1, 1'b0);
    chk("c1_last_wr_en", bus.wr_en, 1'b1);
    chk("c1_last_addr", bus.wr_addr, 15'd19199);
    chk("c1_busy_last", bus.busy, 1'b1);
    chk("c1_done_early", bus.frame_done, 1'b0);
    idle(1);
    chk("c1_done_pulse", bus.frame_done, 1'b1);
    chk("c1_busy_after", bus.busy, 1'b0);
    chk("c1_wr_en_after", bus.wr_en, 1'b0);
    idle(1);
    chk("c1_done_single", bus.frame_done, 1'b0);
    chk("c1_addr0", cap[0], 21'd1);
    chk("c1_addr159", cap[159], 21'd160);
    chk("c1_addr160", cap[160], 21'd2);
    chk("c1_addr319", cap[319], 21'd320);
    chk("c1_addr19199", cap[19199], 21'd19200);
    chk("c1_wr_count", wr_cnt - b, N);
    chk("c1_done_count", done_cnt, 1);
    chk("c1_done_timing", done_cyc, last_wr_cyc + 1);

    // Random pixels with random gaps against a software integral image
    for (int i = 0; i < N; i++) rp[i] = int'($urandom_range(0, 15));
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        ex[y*W+x] = rp[y*W+x]
                  + ((x > 0) ? ex[y*W+x-1] : 0)
                  + ((y > 0) ? ex[(y-1)*W+x] : 0)
                  - ((x > 0 && y > 0) ? ex[(y-1)*W+x-1] : 0);
      end
    end
    idle(3);
    b = wr_cnt;
    gap_chk = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i > 0 && $urandom_range(0, 7) == 0) idle(1);
      pix(i == 0, 4'(rp[i]));
    end
    idle(3);
    gap_chk = 1'b0;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < N; i++) begin
      if (cap[i] !== 21'(ex[i])) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (bad != 0) $display("random frame: first bad addr %0d", first_bad);
    chk("rnd_bad_entries", bad, 0);
    chk("rnd_wr_count", wr_cnt - b, N);
    chk("rnd_gap_writes", gap_err, 0);
    chk("rnd_done_count", done_cnt, 2);

    // Frame aborted at pixel 500, followed by a full pix=15 frame
    b = wr_cnt;
    d = done_cnt;
    send_const(4'd1, 500, 1'b1);
    chk("ab_busy_mid", bus.busy, 1'b1);
    pix(1'b1, 4'd15);
    chk("ab_restart_addr", bus.wr_addr, 15'd0);
    chk("ab_restart_data", bus.wr_data, 21'd15);
    send_const(4'd15, N - 1, 1'b0);
    idle(3);
    chk("ab_done_count", done_cnt - d, 1);
    chk("ab_addr0", cap[0], 21'd15);
    chk("ab_addr160", cap[160], 21'd30);
    chk("ab_addr499", cap[499], 21'd1200);
    chk("ab_addr19199", cap[19199], 21'd288000);
    chk("ab_wr_count", wr_cnt - b, N + 500);
    chk("msb_zero", msb_err, 0);

    // sof under hold_frame is dropped; released hold accepts the next sof
    b = wr_cnt;
    dr = drop_cnt;
    bus.hold_frame = 1'b1;
    pix(1'b1, 4'd5);
    chk("hd_dropped_pulse", bus.frame_dropped, 1'b1);
    chk("hd_no_write", bus.wr_en, 1'b0);
    chk("hd_busy", bus.busy, 1'b0);
    idle(1);
    chk("hd_dropped_single", bus.frame_dropped, 1'b0);
    pix(1'b0, 4'd5);
    idle(1);
    chk("hd_wr_count", wr_cnt - b, 0);
    chk("hd_drop_count", drop_cnt - dr, 1);
    chk("hd_idle_busy", bus.busy, 1'b0);
    bus.hold_frame = 1'b0;
    pix(1'b1, 4'd3);
    chk("hd_accept_wr_en", bus.wr_en, 1'b1);
    chk("hd_accept_addr", bus.wr_addr, 15'd0);
    chk("hd_accept_data", bus.wr_data, 21'd3);
    chk("hd_accept_busy", bus.busy, 1'b1);

    // Asynchronous reset at pixel 8000
    send_const(4'd3, 7999, 1'b0);
    chk("rs_pre_wr_en", bus.wr_en, 1'b1);
    d = done_cnt;
    rst = 1'b0;
    #1;
    chk("rs_wr_en", bus.wr_en, 1'b0);
    chk("rs_busy", bus.busy, 1'b0);
    chk("rs_wr_addr", bus.wr_addr, 15'd0);
    chk("rs_wr_data", bus.wr_data, 21'd0);
    #2;
    rst = 1'b1;
    idle(2);
    chk("rs_busy_after", bus.busy, 1'b0);
    chk("rs_no_done", done_cnt - d, 0);

    // New frame after reset, first 400 pixels of pix=2
    b = wr_cnt;
    send_const(4'd2, 400, 1'b1);
    idle(2);
    chk("nf_addr0", cap[0], 21'd2);
    chk("nf_addr159", cap[159], 21'd320);
    chk("nf_addr160", cap[160], 21'd4);
    chk("nf_addr399", cap[399], 21'd480);
    chk("nf_wr_count", wr_cnt - b, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule

// File: doc/integral_image_builder.md
# integral_image_builder

Streaming integral-image generator feeding the integral image buffer that the Haar-feature classifiers read. Accepts a row-major 160x120 grayscale pixel stream, computes II(x,y) = sum of all pixels p(i,j) with i<=x, j<=y, and writes one 21-bit signed value per pixel to the buffer write port at address y*160+x. Signals frame completion to the detection state machine so classification starts only on a fully written frame, and drops new frames while detection holds the buffer.

## Interface
Parameters:
- II_WIDTH, 160, pixels per row
- II_HEIGHT, 120, rows per frame
- PIX_W, 4, grayscale pixel width (unsigned, max 15)
- DATA_W, 21, integral value width (signed, matches buffer/classifier data)
- ADDR_W, 15, buffer address width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- sof  in  1  start-of-frame strobe, qualifies the first pixel (sampled with pix_valid)
- pix_valid  in  1  pixel present on pix_data this cycle
- pix_data  in  PIX_W  grayscale pixel, unsigned
- hold_frame  in  1  detection in progress; buffer must not be overwritten
- wr_en  out  1  buffer write strobe
- wr_addr  out  ADDR_W  buffer write address, y*II_WIDTH+x
- wr_data  out  DATA_W  signed integral value
- frame_done  out  1  one-cycle pulse, frame fully written
- frame_dropped  out  1  one-cycle pulse, sof rejected due to hold_frame
- busy  out  1  high in ACCUMULATE

## Operation
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_dropped=0, busy=0; state=IDLE; x,y counters, row sum, line buffer contents = 0.
- Internal: x counter (0..159), y counter (0..119), row accumulator (DATA_W), line buffer of II_WIDTH DATA_W entries holding previous row's integral values.
- States (one-hot): IDLE, ACCUMULATE, DONE.
- IDLE: pix_valid&sof&!hold_frame -> accept pixel as (0,0), go ACCUMULATE. pix_valid&sof&hold_frame -> frame_dropped pulse next cycle, stay IDLE. pix_valid without sof ignored.
- ACCUMULATE: each pix_valid cycle accepts one pixel. rowsum' = (x==0 ? 0 : rowsum) + pix; II = rowsum' + (y==0 ? 0 : line[x]); line[x] <= II; x,y advance row-major. Cycles without pix_valid: no state change, no write.
- sof with pix_valid in ACCUMULATE: abort current frame, restart at (0,0) with this pixel (line buffer reads treated as 0 for y==0); no frame_done for aborted frame. hold_frame is not checked mid-frame.
- Pixel (159,119) accepted -> DONE; DONE emits frame_done for one cycle then returns IDLE. pix_valid in DONE ignored.
- Arithmetic: pix zero-extended; max II = 19200*15 = 288000 < 2^20, no overflow, no saturation; MSB of wr_data always 0.

## Timing
- Write latency 1: pixel accepted in cycle N -> wr_en=1 with its wr_addr/wr_data in cycle N+1; wr_en is a single-cycle pulse per pixel.
- Back-to-back pixels give one write per cycle; throughput 1 pixel/clk.
- frame_done asserted in cycle N+2 for last pixel at cycle N (one cycle after final wr_en).
- frame_dropped asserted cycle after the rejected sof.
- rst low mid-frame: all outputs to reset values immediately (asynchronous), partial frame discarded, no frame_done.
- busy=1 from the cycle after first pixel accept through cycle the last pixel is accepted+1.

## Test plan
- Constant frame pix=1, no gaps -> writes addr 0=1, 159=160, 160=2, 319=320, 19199=19200; 19200 writes total; frame_done one cycle after last wr_en.
- Constant frame pix=15 -> addr 19199 = 288000, addr 160 = 30; wr_data[20]=0 throughout.
- Random pixels with random pix_valid gaps -> every wr_data matches software integral image; write count 19200; no wr_en on gap cycles.
- sof reasserted at pixel 500 -> no frame_done for first frame; following writes restart at addr 0 with row 0 values; second frame completes with correct 288000/19200 end value.
- hold_frame=1 at sof in IDLE -> frame_dropped pulse, zero writes, state stays IDLE; release hold_frame, next sof accepted.
- rst pulled low at pixel 8000 -> wr_en and busy low at once; after release, new frame produces correct values from addr 0.
